// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// shift_arbiter : two-port arbiter feeding one shared 32-bit barrel shifter
// Optional macro SHIFT_ARBITER_ROTATE_EN builds rotate-left for op 11.
// Revision 1.0
// ============================================================================
module shift_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_data0,
    input  logic [31:0] req_data1,
    input  logic [4:0]  req_amount0,
    input  logic [4:0]  req_amount1,
    input  logic [1:0]  req_op0,
    input  logic [1:0]  req_op1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_id
);

    localparam logic [1:0] c_OP_SLL = 2'b00;
    localparam logic [1:0] c_OP_SRL = 2'b01;
    localparam logic [1:0] c_OP_SRA = 2'b10;
    localparam logic [1:0] c_OP_ROL = 2'b11;

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic             r_ptr;
    logic [31:0]      r_data;
    logic             r_id;

    logic [1:0]       w_grant;
    logic             w_sel;
    logic             w_free;
    logic             w_xfer;

    logic [31:0]      w_operand;
    logic [4:0]       w_amount;
    logic [1:0]       w_op;
    logic             w_reverse;
    logic             w_fill;
    logic [31:0]      w_rev_in;
    logic [31:0]      w_rev_out;
    logic [31:0]      w_shift_in;
    logic [5:0][31:0] w_stage;
    logic [31:0]      w_result;

    // ---------------------------------------------------------------- arbitration
    always_comb begin
        w_grant = 2'b00;
        case (req_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = ((FIXED_PRIO != 0) || !r_ptr) ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
        endcase
    end

    assign w_sel  = w_grant[1];
    assign w_free = (r_state == S_EMPTY) || rsp_ready;
    assign w_xfer = |(req_valid & req_ready);

    // ---------------------------------------------------------------- result FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY: if (w_xfer) w_state_next = S_FULL;
            S_FULL:  if (w_xfer)         w_state_next = S_FULL;
                     else if (rsp_ready) w_state_next = S_EMPTY;
            default: w_state_next = S_EMPTY;
        endcase
    end

    always_comb begin
        rsp_valid = (r_state == S_FULL);
        req_ready = reset ? 2'b00 : (w_grant & {2{w_free}});
    end

    // ---------------------------------------------------------------- result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= 32'h0;
            r_id   <= 1'b0;
            r_ptr  <= 1'b0;
        end else if (w_xfer) begin
            r_data <= w_result;
            r_id   <= w_sel;
            r_ptr  <= ~w_sel;
        end
    end

    assign rsp_data = r_data;
    assign rsp_id   = r_id;

    // ---------------------------------------------------------------- shared shifter
    assign w_operand = w_sel ? req_data1   : req_data0;
    assign w_amount  = w_sel ? req_amount1 : req_amount0;
    assign w_op      = w_sel ? req_op1     : req_op0;

    // Right shifts reuse the left shifter by mirroring the word on both sides.
    assign w_reverse = (w_op == c_OP_SRL) || (w_op == c_OP_SRA);
    assign w_fill    = (w_op == c_OP_SRA) && w_operand[31];

    always_comb begin
        w_rev_in  = 32'h0;
        w_rev_out = 32'h0;
        for (int b = 0; b < 32; b++) begin
            w_rev_in[b]  = w_operand[31-b];
            w_rev_out[b] = w_stage[5][31-b];
        end
    end

    assign w_shift_in = w_reverse ? w_rev_in : w_operand;
    assign w_stage[0] = w_shift_in;

`ifdef SHIFT_ARBITER_ROTATE_EN
    logic w_rotate;
    assign w_rotate = (w_op == c_OP_ROL);
`endif

    generate
        for (genvar k = 0; k < 5; k++) begin : g_layer
            localparam int c_SHIFT = 1 << k;
            logic [c_SHIFT-1:0] w_low;
`ifdef SHIFT_ARBITER_ROTATE_EN
            // Rotating every layer composes into a full rotate by the total amount.
            assign w_low = w_rotate ? w_stage[k][31 -: c_SHIFT] : {c_SHIFT{w_fill}};
`else
            assign w_low = {c_SHIFT{w_fill}};
`endif
            assign w_stage[k+1] = w_amount[k] ? {w_stage[k][31-c_SHIFT:0], w_low}
                                              : w_stage[k];
        end
    endgenerate

    always_comb begin
        w_result = w_reverse ? w_rev_out : w_stage[5];
`ifndef SHIFT_ARBITER_ROTATE_EN
        if (w_op == c_OP_ROL) w_result = w_operand;
`endif
    end

endmodule
`default_nettype wire

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0; 0 = round-robin arbitration, 1 = port 0 always wins.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 2, per-requester request valid (bit i = port i).
REQ-005 SHALL have port req_ready, output, 2, per-requester accept; a transfer occurs on valid&ready.
REQ-006 SHALL have ports req_data0/req_data1, input, 32 each, operand per port.
REQ-007 SHALL have ports req_amount0/req_amount1, input, 5 each, shift amount per port.
REQ-008 SHALL have ports req_op0/req_op1, input, 2 each, opcode: 00 SLL, 01 SRL, 10 SRA, 11 ROL (see REQ-024).
REQ-009 SHALL have port rsp_valid, output, 1, result register holds a valid result.
REQ-010 SHALL have port rsp_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port rsp_data, output, 32, shifted result.
REQ-012 SHALL have port rsp_id, output, 1, index of the port whose request produced rsp_data.

Function
REQ-013 SHALL contain exactly one shared 32-bit left barrel shifter (5 power-of-two layers, shared fill input); all ops use it.
REQ-014 SRL/SRA SHALL be done by bit-reversing the operand, left-shifting, and bit-reversing the result; fill = 0 for SLL/SRL, operand bit 31 for SRA.
REQ-015 SHALL have a two-state result FSM: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-016 Slot free condition: free = !rsp_valid | rsp_ready.
REQ-017 Grant: at most one req_ready bit high per cycle; req_ready[i] = grant[i] & free; grant is combinational from req_valid and the priority pointer.
REQ-018 Round-robin (FIXED_PRIO=0): when both valid, the pointer port wins; after any accepted transfer from port i the pointer moves to port 1-i; pointer unchanged on cycles with no transfer.
REQ-019 Single valid requester SHALL be granted regardless of pointer.
REQ-020 On an accepted transfer, rsp_data, rsp_id load next edge and rsp_valid=1 next cycle: latency exactly 1 cycle, throughput 1 result/cycle when rsp_ready held high.
REQ-021 FULL with rsp_ready=1 and a new transfer: FSM stays FULL with new result (back-to-back); FULL with rsp_ready=1 and no transfer: go EMPTY.
REQ-022 FULL with rsp_ready=0: rsp_data, rsp_id, rsp_valid SHALL hold; req_ready=0 on both ports; no request is dropped or duplicated.
REQ-023 Amount 0 SHALL return the operand unchanged for all ops; amount 31 SHALL be handled exactly (e.g. SRA of 0x80000000 by 31 = 0xFFFFFFFF).

Configuration
REQ-024 Macro SHIFT_ARBITER_ROTATE_EN: defined -> op 11 = rotate left, result = (x<<n)|(x>>(32-n)), n=0 gives x; undefined -> op 11 returns operand unchanged and no rotate logic is built.

Reset
REQ-025 While reset=1 at an edge: rsp_valid=0, rsp_data=0, rsp_id=0, FSM=EMPTY, pointer=port 0.
REQ-026 req_ready SHALL be 0 in any cycle where reset=1; a request presented during reset is not accepted.
REQ-027 Reset asserted while FULL SHALL discard the held result; first post-reset accept produces result one cycle later.

Verification
REQ-028 Port 0 SLL 0x00000001 by 4, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=0x00000010, rsp_id=0.
REQ-029 Port 1 SRA 0xF0000000 by 4 and SRL same -> 0xFF000000 then 0x0F000000, rsp_id=1 each.
REQ-030 Both ports valid continuously, FIXED_PRIO=0, rsp_ready=1 -> rsp_id alternates 0,1,0,1 starting 0 after reset; FIXED_PRIO=1 -> all rsp_id=0.
REQ-031 Result FULL, rsp_ready=0 for 3 cycles with both valid -> req_ready=00, rsp_data stable 3 cycles; rsp_ready=1 -> next result next cycle, none lost.
REQ-032 Op 11 on 0x80000001 by 1 -> 0x00000003 with SHIFT_ARBITER_ROTATE_EN defined, 0x80000001 without.
REQ-033 Reset asserted while FULL -> rsp_valid=0, rsp_data=0 next cycle; pointer back to port 0.
